disp_scan_ctrl: RTL
===================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 1000: clock cycles each digit is driven per scan slot (legal range 2..65535).
REQ-002 The block SHALL have parameter DEAD, default 8: clock cycles of all-anodes-off gap before each digit slot (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port upd_valid, input, 1 bit: an update value is offered.
REQ-006 The block SHALL have port upd_ready, output, 1 bit: an update can be accepted.
REQ-007 The block SHALL have port upd_value, input, 16 bits: four BCD nibbles, [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-008 The block SHALL have port lz_en, input, 1 bit: leading-zero blanking enable.
REQ-009 The block SHALL have port dig_code, output, 4 bits: code to the shared 7-segment decoder; 0-9 shows a digit, 4'b1010 shows blank.
REQ-010 The block SHALL have port an, output, 4 bits: active-low digit enables; bit i low drives digit i.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.
REQ-012 The block SHALL have port bcd_err, output, 1 bit: sticky flag set when an accepted nibble is greater than 9.

Function
REQ-013 The FSM SHALL have two states: DEADT (an=4'b1111) and DRIVE (an has one bit low, selected by digit index idx, 2 bits).
REQ-014 DEADT SHALL last exactly DEAD cycles, then go to DRIVE with idx advanced by 1, wrapping from 3 to 0.
REQ-015 DRIVE SHALL last exactly DIV cycles, then go to DEADT with idx unchanged.
REQ-016 A frame SHALL be 4*(DIV+DEAD) cycles; the frame boundary is the DEADT->DRIVE transition into idx=0.
REQ-017 dig_code and an SHALL be registered and change only together at state transitions, so no decoder glitch appears on an enabled digit.
REQ-018 In DEADT, dig_code SHALL be 4'b1010.
REQ-019 In DRIVE, dig_code SHALL be the idx nibble of the active register, or 4'b1010 when that nibble is blanked.
REQ-020 Any active nibble greater than 9 SHALL be displayed as 4'b1010.
REQ-021 With lz_en=1, digit i (i=3..1) SHALL be blanked when it and all higher digits are zero; digit 0 SHALL never be blanked by lz_en.
REQ-022 lz_en SHALL be sampled at each DRIVE entry.
REQ-023 Handshake: an update SHALL be accepted in a cycle where upd_valid=1 and upd_ready=1.
REQ-024 On acceptance, upd_value SHALL be captured into a pending register, and upd_ready SHALL go 0 on the next cycle.
REQ-025 upd_valid while upd_ready=0 SHALL be ignored; the offered value is not captured.
REQ-026 At the frame boundary, the active register SHALL load pending, and upd_ready SHALL return to 1 the following cycle, so an update never tears mid-frame.
REQ-027 If acceptance and the frame boundary fall in the same cycle, the new value SHALL stay pending until the next boundary.
REQ-028 frame_done SHALL be 1 exactly in the cycle after the frame boundary transition, which is the first DRIVE cycle with idx=0.
REQ-029 bcd_err SHALL set in the cycle after acceptance of a value containing any nibble greater than 9, and SHALL clear only on reset.
REQ-030 Counters SHALL be 16-bit (DIV) and 8-bit (DEAD), with no overflow within the legal parameter ranges.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set: state=DEADT, idx=3, counters=0, an=4'b1111, dig_code=4'b1010, active=16'h0000, pending cleared, upd_ready=1, frame_done=0, bcd_err=0.
REQ-032 Reset asserted mid-frame SHALL take effect at the next edge, discarding any pending update.
REQ-033 After release, the first DRIVE SHALL be idx=0, starting after DEAD cycles.

Verification (DIV=4, DEAD=2; cycle 1 = first cycle after release)
REQ-034 Scan timing: reset release with no update -> an=1111 in cycles 1-2; an=1110 and dig_code=0 in cycles 3-6; an=1111 in cycles 7-8; an=1101 in cycles 9-12; frame_done pulses in cycles 3 and 27.
REQ-035 Update: accept 16'h1234 in cycle 5 -> upd_ready=0 from cycle 6; digit 0 shows 4 starting cycle 27; upd_ready=1 in cycle 28.
REQ-036 Leading-zero blanking: active=16'h0070 with lz_en=1 -> dig_code sequence 0,7,A,A; same value with lz_en=0 -> 0,7,0,0.
REQ-037 Bad BCD: accept 16'h12F4 -> bcd_err=1 the next cycle and stays 1; after the next boundary, digit 1 shows 4'b1010.
REQ-038 Reset and collisions: rst_n=0 during DRIVE of idx=2 with an update pending -> next cycle an=1111, dig_code=A, upd_ready=1; after re-release, digit 0 shows 0. An update offered at the boundary cycle is displayed one frame later.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl
// Time-multiplexed scan controller for a four-digit common-anode 7-segment
// display sharing one BCD-to-segment decoder.
//
// Every digit slot is a dead-time gap (all anodes off) followed by a drive
// window for one digit. The anode enables and the decoder code are registered
// and always change on the same edge, so the decoder never shows a transient
// value on an enabled digit.
//
// New display values come in through a valid/ready handshake. An accepted
// value waits in a pending register. It is copied to the active register
// only at a frame boundary, so a single frame never mixes old and new digits.
// ---------------------------------------------------------------------------
module disp_scan_ctrl #(
    parameter int DIV  = 1000,  // drive cycles per digit slot (2..65535)
    parameter int DEAD = 8      // blanking cycles ahead of each slot (1..255)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_value,
    input  logic        lz_en,
    output logic [3:0]  dig_code,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        bcd_err
);

    // Decoder code that lights no segments.
    localparam logic [3:0]  BLANK     = 4'b1010;
    localparam logic [3:0]  AN_OFF    = 4'b1111;
    // Terminal counts. Both counters run from zero up to these values.
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [7:0]  DEAD_LAST = 8'(DEAD - 1);

    typedef enum logic {
        DEADT = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Decoder code for digit 'sel' of 'val'. A non-BCD nibble shows as blank.
    // With lz set, a digit above digit 0 is blanked when it and every higher
    // digit are zero. That is the same as saying the value shifted down to
    // this digit is all zero.
    function automatic logic [3:0] digit_code(input logic [15:0] val,
                                              input logic [1:0]  sel,
                                              input logic        lz);
        logic [15:0] upper_v;
        logic [3:0]  nib_v;
        logic        blank_v;
        upper_v = val >> {sel, 2'b00};
        nib_v   = upper_v[3:0];
        blank_v = lz && (sel != 2'd0) && (upper_v == 16'h0000);
        if (blank_v || (nib_v > 4'd9)) begin
            digit_code = BLANK;
        end else begin
            digit_code = nib_v;
        end
    endfunction

    // True when any of the four nibbles is not a legal BCD digit.
    function automatic logic has_bad_bcd(input logic [15:0] val);
        logic bad_v;
        bad_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (val[i*4 +: 4] > 4'd9) begin
                bad_v = 1'b1;
            end else begin
                bad_v = bad_v;
            end
        end
        has_bad_bcd = bad_v;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_r;
    logic [1:0]  idx_r;
    logic [15:0] div_cnt_r;
    logic [7:0]  dead_cnt_r;
    logic [3:0]  an_r;
    logic [3:0]  dig_code_r;
    logic        frame_done_r;

    logic [15:0] active_r;
    logic [15:0] pending_r;
    logic        pend_valid_r;
    logic        upd_ready_r;
    logic        bcd_err_r;

    // Combinational decode of the current cycle.
    logic        dead_end_s;
    logic        drive_end_s;
    logic        boundary_s;
    logic        load_s;
    logic        accept_s;
    logic [1:0]  idx_next_s;
    logic [15:0] src_value_s;
    logic [3:0]  entry_code_s;

    // Slot-end detection, frame boundary and the code for the next drive window.
    always_comb begin
        dead_end_s  = (state_r == DEADT) && (dead_cnt_r == DEAD_LAST);
        drive_end_s = (state_r == DRIVE) && (div_cnt_r == DIV_LAST);
        idx_next_s  = idx_r + 2'd1;
        // The frame boundary is the dead-time exit that wraps back to digit 0.
        boundary_s  = dead_end_s && (idx_r == 2'd3);
        load_s      = boundary_s && pend_valid_r;
        accept_s    = upd_valid && upd_ready_r;
        // On a boundary that loads a new value, the digit-0 code must come
        // from that value. Otherwise the first digit would show stale data.
        if (load_s) begin
            src_value_s = pending_r;
        end else begin
            src_value_s = active_r;
        end
        entry_code_s = digit_code(src_value_s, idx_next_s, lz_en);
    end

    // Scan FSM: dead-time and drive counters, digit index and the registered
    // anode and decoder outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= DEADT;
            idx_r        <= 2'd3;
            div_cnt_r    <= 16'd0;
            dead_cnt_r   <= 8'd0;
            an_r         <= AN_OFF;
            dig_code_r   <= BLANK;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                DEADT: begin
                    if (dead_end_s) begin
                        state_r      <= DRIVE;
                        idx_r        <= idx_next_s;
                        dead_cnt_r   <= 8'd0;
                        div_cnt_r    <= 16'd0;
                        an_r         <= ~(4'b0001 << idx_next_s);
                        dig_code_r   <= entry_code_s;
                        frame_done_r <= boundary_s;
                    end else begin
                        dead_cnt_r   <= dead_cnt_r + 8'd1;
                    end
                end
                DRIVE: begin
                    if (drive_end_s) begin
                        state_r    <= DEADT;
                        div_cnt_r  <= 16'd0;
                        dead_cnt_r <= 8'd0;
                        an_r       <= AN_OFF;
                        dig_code_r <= BLANK;
                    end else begin
                        div_cnt_r  <= div_cnt_r + 16'd1;
                    end
                end
                default: begin
                    // Unreachable encoding: go back to a safe blanked slot.
                    state_r    <= DEADT;
                    idx_r      <= 2'd3;
                    div_cnt_r  <= 16'd0;
                    dead_cnt_r <= 8'd0;
                    an_r       <= AN_OFF;
                    dig_code_r <= BLANK;
                end
            endcase
        end
    end

    // Update handshake: capture into pending, move pending to active at the
    // frame boundary, and keep the sticky BCD error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_r     <= 16'h0000;
            pending_r    <= 16'h0000;
            pend_valid_r <= 1'b0;
            upd_ready_r  <= 1'b1;
            bcd_err_r    <= 1'b0;
        end else begin
            if (load_s) begin
                active_r <= pending_r;
            end else begin
                active_r <= active_r;
            end

            // Ready is low whenever pend_valid is set, so an accept and a
            // load can never happen in the same cycle. An accept that lands
            // on the boundary cycle stays pending until the next boundary.
            if (accept_s) begin
                pending_r    <= upd_value;
                pend_valid_r <= 1'b1;
            end else if (load_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end

            // Ready comes back in the cycle after frame_done, and only if
            // nothing is still waiting for a later boundary.
            if (accept_s) begin
                upd_ready_r <= 1'b0;
            end else if (frame_done_r && !pend_valid_r) begin
                upd_ready_r <= 1'b1;
            end else begin
                upd_ready_r <= upd_ready_r;
            end

            if (accept_s && has_bad_bcd(upd_value)) begin
                bcd_err_r <= 1'b1;
            end else begin
                bcd_err_r <= bcd_err_r;
            end
        end
    end

    assign an         = an_r;
    assign dig_code   = dig_code_r;
    assign frame_done = frame_done_r;
    assign upd_ready  = upd_ready_r;
    assign bcd_err    = bcd_err_r;

endmodule
